uart_tx_arbiter: RTL



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM state encoding, data width and a
// constant-foldable clog2 used for parameter-derived widths.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

  // Bits needed to index n items; never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker; zero latency, no backpressure of its own.
// With lock set only lock_id is eligible, otherwise the first request at or after ptr wins.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             lock,
  input  logic [ID_W-1:0]  lock_id,
  output logic             vld,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    vld = 1'b0;
    idx = '0;
    if (lock) begin
      vld = req[lock_id];
      idx = lock_id;
    end else begin
      // Walk downward so the candidate nearest the pointer is assigned last and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % N_REQ]) begin
          vld = 1'b1;
          idx = ID_W'((int'(ptr) + k) % N_REQ);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX among N_REQ byte sources: round-robin with packet lock, inter-frame gap, ACK timeout.
// Accept -> tx_start next cycle; req_ready pulses only in IDLE while tx_ready is high.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 16,
  localparam int ID_W       = clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_lock,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic             locked;
  logic [CNT_W-1:0] cnt;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_idx;
  logic             accept;
  logic             timeout;

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .lock    (locked),
    .lock_id (grant_id),
    .vld     (pick_vld),
    .idx     (pick_idx)
  );

  assign accept   = (state == ST_IDLE) && tx_ready && pick_vld;
  // A falling tx_ready in the last allowed cycle still counts as an acknowledge.
  assign timeout  = (state == ST_WAIT_ACK) && tx_ready && (cnt == ACK_LAST);
  assign tx_start = (state == ST_START);
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_ready[pick_idx] = 1'b1;
          state_nxt           = ST_START;
        end
      end
      ST_START:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!tx_ready)    state_nxt = ST_WAIT_DONE;
        else if (timeout) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_WAIT_DONE: begin
        if (tx_ready) state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      rr_ptr      <= '0;
      err_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        tx_data  <= req_data[pick_idx*DATA_W +: DATA_W];
        grant_id <= pick_idx;
        locked   <= req_lock[pick_idx];
        // The pointer only moves once a packet closes, so a locked burst keeps its slot.
        if (!req_lock[pick_idx]) rr_ptr <= (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
      end
      if (timeout) err_timeout <= 1'b1;
      if (state_nxt == ST_GAP && state != ST_GAP) cnt <= '0;
      else if (state == ST_START)                 cnt <= CNT_W'(1);
      else if (state == ST_WAIT_ACK || state == ST_GAP) cnt <= cnt + CNT_W'(1);
      else                                        cnt <= '0;
    end
  end

endmodule
